packet_fifo: RTL and testbench

PACKET_FIFO -- requirements
Module: packet_fifo

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ram.sv | 30 +++
 rtl/packet_fifo.sv | 149 ++++++++++++++
 tb/tb_packet_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the packet FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    // PACKET_MODE encodings
    localparam int MODE_STREAM   = 0;
    localparam int MODE_PACKET   = 1;

    // WRITE_WHEN_FULL encodings
    localparam int WWF_STALL     = 0;
    localparam int WWF_OVERWRITE = 1;

    // Ceiling log2 for sizing address buses from entry counts
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for the packet FIFO, no reset on contents.
// Latency: write lands on the rising edge, read is combinational (async).
// Backpressure: none; the caller gates wr_en.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 256,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/packet_fifo.sv
// Stream FIFO with optional store-and-forward packet mode and optional overwrite-oldest.
// Latency: an accepted word is visible on the output the cycle after acceptance.
// Backpressure: in_tready drops when full (unless overwriting); output holds while out_tready is low.
module packet_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH_EXP       = 8,
    parameter int PACKET_MODE     = 0,
    parameter int WRITE_WHEN_FULL = 0,
    parameter int AFULL_LEVEL     = 2**DEPTH_EXP - 4,
    parameter int AEMPTY_LEVEL    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic                  in_tlast,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic [DEPTH_EXP:0]    num_used,
    output logic [DEPTH_EXP:0]    num_free,
    output logic [DEPTH_EXP:0]    pkt_count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  oversize
);

    localparam int PW    = DEPTH_EXP + 1;
    localparam int DEPTH = 2**DEPTH_EXP;
    localparam logic [PW-1:0] DEPTH_CNT  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_LEVEL);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam bit IS_PACKET     = (PACKET_MODE == MODE_PACKET);
    localparam bit CAN_OVERWRITE = (WRITE_WHEN_FULL != WWF_STALL);

    // Overwrite would break packet boundaries, and the watermarks must not overlap
    if (PACKET_MODE == MODE_PACKET && WRITE_WHEN_FULL == WWF_OVERWRITE) begin : g_err_mode
        $error("packet_fifo: WRITE_WHEN_FULL=1 is illegal with PACKET_MODE=1");
    end
    if (AEMPTY_LEVEL >= AFULL_LEVEL) begin : g_err_level
        $error("packet_fifo: AEMPTY_LEVEL must be below AFULL_LEVEL");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PW-1:0]         top;
    logic [PW-1:0]         bottom;
    logic [PW-1:0]         pkt_cnt;
    logic [PW-1:0]         pkt_nxt;
    logic                  overflow_q;
    logic                  oversize_q;
    logic                  escape_q;
    logic                  full;
    logic                  empty;
    logic                  esc_now;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  discard;
    logic                  pop;
    logic [DATA_WIDTH:0]   rd_entry;

    assign num_used = top - bottom;
    assign num_free = DEPTH_CNT - num_used;
    assign full     = (num_used == DEPTH_CNT);
    assign empty    = (num_used == '0);

    // A full FIFO holding no tlast can never complete a packet, so let it drain
    assign esc_now  = IS_PACKET && full && (pkt_cnt == '0);

    assign in_tready  = !full || CAN_OVERWRITE;
    assign out_tvalid = !empty && (!IS_PACKET || (pkt_cnt != '0) || escape_q || esc_now);

    assign wr_acc  = in_tvalid && in_tready;
    assign rd_acc  = out_tvalid && out_tready;
    // Only a write into a full FIFO with no concurrent read drops the oldest word
    assign discard = wr_acc && full && !rd_acc;
    assign pop     = rd_acc || discard;

    assign out_tdata    = rd_entry[DATA_WIDTH-1:0];
    assign out_tlast    = rd_entry[DATA_WIDTH];
    assign pkt_count    = pkt_cnt;
    assign almost_full  = (num_used >= AFULL_CNT);
    assign almost_empty = (num_used <= AEMPTY_CNT);
    assign overflow     = overflow_q;
    assign oversize     = oversize_q;

    // Next packet count: tlast written in, tlast leaving the bottom (read or discarded)
    always_comb begin
        pkt_nxt = pkt_cnt;
        if (wr_acc && in_tlast) begin
            pkt_nxt = pkt_nxt + PTR_ONE;
        end
        if (pop && out_tlast) begin
            pkt_nxt = pkt_nxt - PTR_ONE;
        end
    end

    // Pointer and packet-count state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top     <= '0;
            bottom  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (wr_acc) begin
                top <= top + PTR_ONE;
            end
            if (pop) begin
                bottom <= bottom + PTR_ONE;
            end
            pkt_cnt <= pkt_nxt;
        end
    end

    // Sticky error flags and the oversize escape, which lasts until a tlast leaves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            oversize_q <= 1'b0;
            escape_q   <= 1'b0;
        end else begin
            overflow_q <= overflow_q | discard;
            oversize_q <= oversize_q | esc_now;
            if (pop && out_tlast) begin
                escape_q <= 1'b0;
            end else if (esc_now) begin
                escape_q <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (top[DEPTH_EXP-1:0]),
        .wr_data ({in_tlast, in_tdata}),
        .rd_addr (bottom[DEPTH_EXP-1:0]),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo: three 8-deep instances (stream, stream+overwrite, packet).
// Latency: checks sampled on the falling edge and 2 time units after it.
// Backpressure: randomized out_tready against a queue-based reference model.
module tb_packet_fifo;

    localparam int N   = 3;
    localparam int DEP = 8;
    localparam int AFL = 6;
    localparam int AEL = 2;
    localparam int PMV [N] = '{0, 0, 1};
    localparam int WWV [N] = '{0, 1, 0};

    logic       clk;
    logic       reset;
    logic       in_tvalid    [N];
    logic       in_tready    [N];
    logic       in_tlast     [N];
    logic [7:0] in_tdata     [N];
    logic       out_tvalid   [N];
    logic       out_tready   [N];
    logic       out_tlast    [N];
    logic [7:0] out_tdata    [N];
    logic [3:0] num_used     [N];
    logic [3:0] num_free     [N];
    logic [3:0] pkt_count    [N];
    logic       almost_full  [N];
    logic       almost_empty [N];
    logic       overflow     [N];
    logic       oversize     [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        packet_fifo #(
            .DATA_WIDTH      (8),
            .DEPTH_EXP       (3),
            .PACKET_MODE     (PMV[g]),
            .WRITE_WHEN_FULL (WWV[g]),
            .AFULL_LEVEL     (AFL),
            .AEMPTY_LEVEL    (AEL)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_tvalid    (in_tvalid[g]),
            .in_tready    (in_tready[g]),
            .in_tlast     (in_tlast[g]),
            .in_tdata     (in_tdata[g]),
            .out_tvalid   (out_tvalid[g]),
            .out_tready   (out_tready[g]),
            .out_tlast    (out_tlast[g]),
            .out_tdata    (out_tdata[g]),
            .num_used     (num_used[g]),
            .num_free     (num_free[g]),
            .pkt_count    (pkt_count[g]),
            .almost_full  (almost_full[g]),
            .almost_empty (almost_empty[g]),
            .overflow     (overflow[g]),
            .oversize     (oversize[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of {tlast, data} per instance plus sticky flags
    logic [8:0] mq [N][$];
    bit m_ovf [N];
    bit m_ovs [N];
    bit m_esc [N];

    typedef struct {
        int       k;
        bit       vld;
        bit       last;
        bit [7:0] data;
        bit       rdy;
        bit       e_vld;
        bit       e_rdy;
        bit       e_afull;
        int       e_used;
        int       e_pc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tlast_count(input int k);
        int c;
        c = 0;
        foreach (mq[k][i]) begin
            if (mq[k][i][8]) c++;
        end
        return c;
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < N; k++) begin
            in_tvalid[k]  = 1'b0;
            in_tlast[k]   = 1'b0;
            in_tdata[k]   = 8'h00;
            out_tready[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_ovs[k] = 1'b0;
            m_esc[k] = 1'b0;
        end
    endtask

    // One clock: called on the falling edge with inputs already driven
    task automatic tick();
        bit rd [N];
        bit wr [N];
        bit esc_now [N];
        bit full [N];
        bit ovalid;
        bit tready;
        bit last_rd;
        int sz;
        int pc;
        #2;
        for (int k = 0; k < N; k++) begin
            sz         = mq[k].size();
            pc         = tlast_count(k);
            full[k]    = (sz == DEP);
            esc_now[k] = (PMV[k] == 1) && full[k] && (pc == 0);
            ovalid     = (sz > 0) && ((PMV[k] == 0) || (pc > 0) || m_esc[k] || esc_now[k]);
            tready     = !full[k] || (WWV[k] == 1);
            rd[k]      = ovalid && out_tready[k];
            wr[k]      = in_tvalid[k] && tready;
            chk($sformatf("u%0d.out_tvalid", k), out_tvalid[k], ovalid);
            chk($sformatf("u%0d.in_tready", k), in_tready[k], tready);
            chk($sformatf("u%0d.num_used", k), num_used[k], sz);
            chk($sformatf("u%0d.num_free", k), num_free[k], DEP - sz);
            chk($sformatf("u%0d.pkt_count", k), pkt_count[k], pc);
            chk($sformatf("u%0d.almost_full", k), almost_full[k], sz >= AFL);
            chk($sformatf("u%0d.almost_empty", k), almost_empty[k], sz <= AEL);
            chk($sformatf("u%0d.overflow", k), overflow[k], m_ovf[k]);
            chk($sformatf("u%0d.oversize", k), oversize[k], m_ovs[k]);
            if (sz > 0) begin
                chk($sformatf("u%0d.out_tdata", k), out_tdata[k], mq[k][0][7:0]);
                chk($sformatf("u%0d.out_tlast", k), out_tlast[k], mq[k][0][8]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            last_rd = 1'b0;
            if (rd[k]) begin
                last_rd = mq[k][0][8];
                void'(mq[k].pop_front());
            end
            if (wr[k]) begin
                if (full[k] && !rd[k]) begin
                    void'(mq[k].pop_front());
                    m_ovf[k] = 1'b1;
                end
                mq[k].push_back({in_tlast[k], in_tdata[k]});
            end
            if (rd[k] && last_rd) m_esc[k] = 1'b0;
            else if (esc_now[k])  m_esc[k] = 1'b1;
            if (esc_now[k]) m_ovs[k] = 1'b1;
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the outputs react before any clock edge
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        clear_inputs();
        model_reset();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst%0d.out_tvalid", k), out_tvalid[k], 0);
            chk($sformatf("rst%0d.num_used", k), num_used[k], 0);
            chk($sformatf("rst%0d.num_free", k), num_free[k], DEP);
            chk($sformatf("rst%0d.almost_empty", k), almost_empty[k], 1);
            chk($sformatf("rst%0d.almost_full", k), almost_full[k], 0);
            chk($sformatf("rst%0d.in_tready", k), in_tready[k], 1);
            chk($sformatf("rst%0d.overflow", k), overflow[k], 0);
            chk($sformatf("rst%0d.oversize", k), oversize[k], 0);
            chk($sformatf("rst%0d.pkt_count", k), pkt_count[k], 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_word(input int k, input int data, input bit last);
        clear_inputs();
        in_tvalid[k] = 1'b1;
        in_tdata[k]  = 8'(data);
        in_tlast[k]  = last;
        tick();
    endtask

    initial begin
        int k;
        int used;
        int wp;
        int rp;
        reset = 1'b0;
        clear_inputs();
        model_reset();

        // Directed vectors: fill the stream FIFO past full, then a 3-word packet
        for (int i = 0; i < 10; i++) begin
            used = (i < DEP) ? i : DEP;
            tbl[i] = '{k: 0, vld: (i < 9), last: 1'b0, data: 8'(i), rdy: 1'b0,
                       e_vld: (used > 0), e_rdy: (i < DEP), e_afull: (used >= AFL),
                       e_used: used, e_pc: 0};
        end
        tbl[10] = '{k: 2, vld: 1, last: 0, data: 8'h10, rdy: 0, e_vld: 0, e_rdy: 1, e_afull: 0, e_used: 0, e_pc: 0};
        tbl[11] = '{k: 2, vld: 1, last: 0, data: 8'h11, rdy: 0, e_vld: 0, e_rdy: 1, e_afull: 0, e_used: 1, e_pc: 0};
        tbl[12] = '{k: 2, vld: 1, last: 1, data: 8'h12, rdy: 0, e_vld: 0, e_rdy: 1, e_afull: 0, e_used: 2, e_pc: 0};
        tbl[13] = '{k: 2, vld: 0, last: 0, data: 8'h00, rdy: 0, e_vld: 1, e_rdy: 1, e_afull: 0, e_used: 3, e_pc: 1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            clear_inputs();
            k             = tbl[i].k;
            in_tvalid[k]  = tbl[i].vld;
            in_tlast[k]   = tbl[i].last;
            in_tdata[k]   = tbl[i].data;
            out_tready[k] = tbl[i].rdy;
            chk($sformatf("vec%0d.out_tvalid", i), out_tvalid[k], tbl[i].e_vld);
            chk($sformatf("vec%0d.in_tready", i), in_tready[k], tbl[i].e_rdy);
            chk($sformatf("vec%0d.almost_full", i), almost_full[k], tbl[i].e_afull);
            chk($sformatf("vec%0d.num_used", i), num_used[k], tbl[i].e_used);
            chk($sformatf("vec%0d.pkt_count", i), pkt_count[k], tbl[i].e_pc);
            tick();
        end

        // Overwrite-oldest: full with 0..7, writing 8 drops word 0
        do_reset();
        for (int i = 0; i < 8; i++) write_word(1, i, 1'b0);
        write_word(1, 8, 1'b0);
        clear_inputs();
        chk("wwf.overflow", overflow[1], 1);
        chk("wwf.out_tdata", out_tdata[1], 1);
        chk("wwf.num_used", num_used[1], 8);
        tick();

        // Packet mode: 8 words without tlast must escape and drain in order
        for (int i = 0; i < 8; i++) write_word(2, 8'h40 + i, 1'b0);
        clear_inputs();
        tick();
        chk("ovs.oversize", oversize[2], 1);
        chk("ovs.out_tvalid", out_tvalid[2], 1);
        chk("ovs.num_used", num_used[2], 8);
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            out_tready[2] = 1'b1;
            chk($sformatf("ovs.drain%0d", i), out_tdata[2], 8'h40 + i);
            tick();
        end
        clear_inputs();
        chk("ovs.empty_used", num_used[2], 0);
        chk("ovs.empty_valid", out_tvalid[2], 0);

        // Full with simultaneous write and read: occupancy and order hold, no overflow
        do_reset();
        for (int i = 0; i < 8; i++) write_word(1, i, 1'b0);
        for (int i = 0; i < 20; i++) begin
            clear_inputs();
            in_tvalid[1]  = 1'b1;
            in_tdata[1]   = 8'(8 + i);
            out_tready[1] = 1'b1;
            chk($sformatf("wr_rd%0d.num_used", i), num_used[1], 8);
            chk($sformatf("wr_rd%0d.out_tdata", i), out_tdata[1], i);
            chk($sformatf("wr_rd%0d.overflow", i), overflow[1], 0);
            tick();
        end
        clear_inputs();
        chk("wr_rd.final_used", num_used[1], 8);
        chk("wr_rd.final_overflow", overflow[1], 0);

        // Reset in the middle of a stream, then a fresh word reads back
        do_reset();
        for (int i = 0; i < 5; i++) write_word(0, 8'h30 + i, 1'b0);
        clear_inputs();
        in_tvalid[0] = 1'b1;
        in_tdata[0]  = 8'h77;
        do_reset();
        write_word(0, 8'hA5, 1'b1);
        clear_inputs();
        chk("post_rst.out_tvalid", out_tvalid[0], 1);
        chk("post_rst.out_tdata", out_tdata[0], 8'hA5);
        chk("post_rst.num_used", num_used[0], 1);
        chk("post_rst.pkt_count", pkt_count[0], 1);
        tick();

        // Randomized traffic, alternating fill-heavy and drain-heavy phases
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            wp = (((c / 200) % 2) == 0) ? 80 : 35;
            rp = (((c / 200) % 2) == 0) ? 30 : 75;
            for (int j = 0; j < N; j++) begin
                in_tvalid[j]  = ($urandom_range(99) < wp);
                in_tdata[j]   = 8'($urandom);
                in_tlast[j]   = (PMV[j] == 1) ? ($urandom_range(9) == 0) : ($urandom_range(3) == 0);
                out_tready[j] = ($urandom_range(99) < rp);
            end
            tick();
        end
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
